// File: rtl/kanade_mem_arbiter.sv
// kanade_mem_arbiter
//
// Shares one single-port synchronous main RAM between the video fetch master (m0),
// the CPU data port (m1) and the CPU instruction fetch port (m2). At most one RAM
// access is issued per cycle. Read data is routed back to the originating master
// after the fixed RAM read latency by a small tag pipeline.
//
// Priority: video first, but once video has been granted STARVE_MAX times in a
// row while a CPU port was waiting, the next slot goes to the CPU. The two CPU
// ports share CPU slots by round-robin.

module kanade_mem_arbiter #(
  parameter int unsigned RAM_AW     = 14, // RAM word-address width
  parameter int unsigned RD_LAT     = 1,  // RAM read latency, 1..4
  parameter int unsigned STARVE_MAX = 4   // video grants allowed while CPU waits, 1..15
) (
  input  logic              clk,
  input  logic              reset_n,

  // Video read master
  input  logic              m0_req,
  input  logic [31:0]       m0_addr,
  output logic              m0_gnt,
  output logic              m0_rvalid,

  // CPU data master
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [3:0]        m1_be,
  input  logic [31:0]       m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,

  // CPU instruction fetch master
  input  logic              m2_req,
  input  logic [31:0]       m2_addr,
  output logic              m2_gnt,
  output logic              m2_rvalid,

  // Shared read data, qualified by mN_rvalid
  output logic [31:0]       rdata,

  // RAM macro interface
  output logic              ram_en,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  // Master identifiers carried down the read-return pipeline.
  typedef enum logic [1:0] {
    MstVideo = 2'd0,
    MstData  = 2'd1,
    MstFetch = 2'd2
  } mst_e;

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  // Arbitration terms
  logic              cpu_req;
  logic              starve;
  logic              win_video;
  logic              win_data;
  logic              win_fetch;
  logic              grant_any;

  // Arbiter state: rr=0 prefers m1, rr=1 prefers m2; cnt counts video grants
  // taken while a CPU request was waiting.
  logic              rr_q, rr_d;
  logic [3:0]        cnt_q, cnt_d;

  // Read-return tag pipeline, stage RD_LAT-1 lines up with ram_rdata.
  logic              push_vld;
  mst_e              push_id;
  logic [RD_LAT-1:0] tag_vld_q;
  mst_e              tag_id_q [RD_LAT];

  // Word addresses; byte offset and bits above the RAM size are ignored so
  // out-of-range addresses alias into the RAM.
  logic [RAM_AW-1:0] word0;
  logic [RAM_AW-1:0] word1;
  logic [RAM_AW-1:0] word2;
  logic              unused_addr_bits;

  assign word0 = m0_addr[RAM_AW+1:2];
  assign word1 = m1_addr[RAM_AW+1:2];
  assign word2 = m2_addr[RAM_AW+1:2];

  assign unused_addr_bits = ^{m0_addr[31:RAM_AW+2], m0_addr[1:0],
                              m1_addr[31:RAM_AW+2], m1_addr[1:0],
                              m2_addr[31:RAM_AW+2], m2_addr[1:0]};

  // Pick a winner: starvation override, then video, then CPU by round-robin.
  always_comb begin
    cpu_req   = m1_req | m2_req;
    starve    = cpu_req && (cnt_q >= StarveMax);
    win_video = m0_req && !starve;
    win_data  = !win_video && m1_req && (!m2_req || !rr_q);
    win_fetch = !win_video && m2_req && !win_data;
  end

  // Grants are held low while reset is asserted so nothing reaches the RAM.
  always_comb begin
    m0_gnt    = reset_n & win_video;
    m1_gnt    = reset_n & win_data;
    m2_gnt    = reset_n & win_fetch;
    grant_any = m0_gnt | m1_gnt | m2_gnt;
  end

  // Drive the RAM command from the granted master.
  always_comb begin
    ram_en    = grant_any;
    ram_we    = m1_gnt & m1_we;
    ram_be    = m1_gnt ? m1_be : 4'b1111;
    ram_wdata = m1_wdata;
    if (m1_gnt) begin
      ram_addr = word1;
    end else if (m2_gnt) begin
      ram_addr = word2;
    end else begin
      ram_addr = word0;
    end
  end

  // Next-state for the arbiter registers and the tag pushed this cycle.
  always_comb begin
    // A video grant only advances the count while the CPU is kept waiting;
    // any CPU grant or an idle CPU clears it.
    cnt_d = '0;
    if (m0_gnt && cpu_req) begin
      cnt_d = cnt_q + 4'd1;
    end

    rr_d = rr_q;
    if (m1_gnt) begin
      rr_d = 1'b1;
    end else if (m2_gnt) begin
      rr_d = 1'b0;
    end

    // Writes and idle cycles push an empty slot so later reads stay aligned.
    push_vld = grant_any && !ram_we;
    push_id  = MstVideo;
    if (m1_gnt) begin
      push_id = MstData;
    end else if (m2_gnt) begin
      push_id = MstFetch;
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      rr_q  <= rr_d;
      cnt_q <= cnt_d;
    end
  end

  // Tag pipeline; reset drops any reads still in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_vld_q <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        tag_id_q[i] <= MstVideo;
      end
    end else begin
      tag_vld_q[0] <= push_vld;
      tag_id_q[0]  <= push_id;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
    end
  end

  // Steer the returning read to its owner; data is passed straight through.
  always_comb begin
    m0_rvalid = tag_vld_q[RD_LAT-1] && (tag_id_q[RD_LAT-1] == MstVideo);
    m1_rvalid = tag_vld_q[RD_LAT-1] && (tag_id_q[RD_LAT-1] == MstData);
    m2_rvalid = tag_vld_q[RD_LAT-1] && (tag_id_q[RD_LAT-1] == MstFetch);
    rdata     = ram_rdata;
  end

endmodule

// File: tb/tb_kanade_mem_arbiter.sv
// Testbench for kanade_mem_arbiter: directed scenarios plus a randomized run
// checked against a behavioural model (shadow memory + expected-return queue).

module tb_kanade_mem_arbiter;

  localparam int unsigned AW    = 10;
  localparam int unsigned L     = 3;
  localparam int unsigned SM    = 4;
  localparam int unsigned WORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          m0_req, m1_req, m2_req, m1_we;
  logic [3:0]    m1_be;
  logic [31:0]   m0_addr, m1_addr, m2_addr, m1_wdata;
  logic          m0_gnt, m1_gnt, m2_gnt, m0_rvalid, m1_rvalid, m2_rvalid;
  logic [31:0]   rdata;
  logic          ram_en, ram_we;
  logic [3:0]    ram_be;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata, ram_rdata;

  logic [2:0]    gnts, rvs;
  assign gnts = {m2_gnt, m1_gnt, m0_gnt};
  assign rvs  = {m2_rvalid, m1_rvalid, m0_rvalid};

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  kanade_mem_arbiter #(.RAM_AW(AW), .RD_LAT(L), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m2_req(m2_req), .m2_addr(m2_addr), .m2_gnt(m2_gnt), .m2_rvalid(m2_rvalid),
    .rdata(rdata), .ram_en(ram_en), .ram_we(ram_we), .ram_be(ram_be),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  function automatic logic [31:0] init_word(int i);
    logic [31:0] x = 32'(i);
    if (i == 4) return 32'hDEAD_BEEF;
    return (x * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  // RAM macro model with L-cycle read latency.
  logic        preload;
  logic [31:0] ram     [WORDS];
  logic [31:0] rd_pipe [L];
  logic [31:0] shadow  [WORDS];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < int'(WORDS); i++) ram[i] <= init_word(i);
    end else if (ram_en && ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    rd_pipe[0] <= ram[ram_addr];
    for (int i = 1; i < int'(L); i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_rdata = rd_pipe[L-1];

  typedef struct {
    int          due;
    int          id;
    logic [31:0] data;
  } ret_t;
  ret_t exp_q[$];

  task automatic idle_inputs();
    m0_req = 1'b0; m1_req = 1'b0; m2_req = 1'b0; m1_we = 1'b0; m1_be = 4'hF;
    m0_addr = '0; m1_addr = '0; m2_addr = '0; m1_wdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    m0_req = 1'b1; m1_req = 1'b1; m2_req = 1'b1; m1_we = 1'b1;
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (gnts !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b want 000", gnts); end
    checks++;
    if ({ram_en, ram_we} !== 2'b00) begin
      errors++; $display("FAIL reset_ram: en/we got %b want 00", {ram_en, ram_we});
    end
    checks++;
    if (rvs !== 3'b000) begin errors++; $display("FAIL reset_rvalid: got %b want 000", rvs); end
    tick();
    idle_inputs();
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({ram_en, ram_we} !== 2'b00) begin
      errors++; $display("FAIL idle_ram: en/we got %b want 00", {ram_en, ram_we});
    end
    checks++;
    if (gnts !== 3'b000) begin errors++; $display("FAIL idle_gnt: got %b want 000", gnts); end
    tick();
  endtask

  task automatic test_single_read();
    idle_inputs();
    m2_req = 1'b1; m2_addr = 32'h0000_0010;
    @(negedge clk);
    checks++;
    if (gnts !== 3'b100) begin errors++; $display("FAIL single_gnt: got %b want 100", gnts); end
    checks++;
    if ({ram_en, ram_we} !== 2'b10) begin
      errors++; $display("FAIL single_en: en/we got %b want 10", {ram_en, ram_we});
    end
    checks++;
    if (ram_addr !== AW'(4)) begin errors++; $display("FAIL single_addr: got %0d want 4", ram_addr); end
    checks++;
    if (ram_be !== 4'hF) begin errors++; $display("FAIL single_be: got %b want 1111", ram_be); end
    tick();
    m2_req = 1'b0;
    for (int k = 1; k <= int'(L) + 1; k++) begin
      @(negedge clk);
      checks++;
      if (rvs !== ((k == int'(L)) ? 3'b100 : 3'b000)) begin
        errors++; $display("FAIL single_rvalid: cycle +%0d got %b", k, rvs);
      end
      if (k == int'(L)) begin
        checks++;
        if (rdata !== 32'hDEAD_BEEF) begin
          errors++; $display("FAIL single_rdata: got %h want deadbeef", rdata);
        end
      end
    end
    tick();
  endtask

  task automatic test_write();
    logic [31:0] w0;
    logic [31:0] want;
    w0   = init_word(8);
    want = {w0[31:16], 16'h5678};
    idle_inputs();
    m1_req = 1'b1; m1_we = 1'b1; m1_be = 4'b0011;
    m1_addr = 32'h0000_0020; m1_wdata = 32'h1234_5678;
    @(negedge clk);
    checks++;
    if (gnts !== 3'b010) begin errors++; $display("FAIL write_gnt: got %b want 010", gnts); end
    checks++;
    if ({ram_en, ram_we} !== 2'b11) begin
      errors++; $display("FAIL write_we: en/we got %b want 11", {ram_en, ram_we});
    end
    checks++;
    if (ram_be !== 4'b0011) begin errors++; $display("FAIL write_be: got %b want 0011", ram_be); end
    checks++;
    if (ram_addr !== AW'(8)) begin errors++; $display("FAIL write_addr: got %0d want 8", ram_addr); end
    checks++;
    if (ram_wdata !== 32'h1234_5678) begin
      errors++; $display("FAIL write_wdata: got %h want 12345678", ram_wdata);
    end
    shadow[8] = want;
    tick();
    m1_we = 1'b0;
    @(negedge clk);
    checks++;
    if ({gnts, ram_we} !== 4'b0100) begin
      errors++; $display("FAIL readback_gnt: gnt/we got %b want 0100", {gnts, ram_we});
    end
    tick();
    m1_req = 1'b0;
    for (int k = 1; k <= int'(L) + 1; k++) begin
      @(negedge clk);
      checks++;
      if (rvs !== ((k == int'(L)) ? 3'b010 : 3'b000)) begin
        errors++; $display("FAIL write_rvalid: cycle +%0d got %b", k, rvs);
      end
      if (k == int'(L)) begin
        checks++;
        if (rdata !== want) begin errors++; $display("FAIL readback_data: got %h want %h", rdata, want); end
      end
    end
    tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    m1_req = 1'b1; m1_addr = 32'h40;
    m2_req = 1'b1; m2_addr = 32'h80;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (gnts !== ((i % 2 == 0) ? 3'b010 : 3'b100)) begin
        errors++; $display("FAIL rr_gnt: slot %0d got %b", i, gnts);
      end
      checks++;
      if (ram_addr !== ((i % 2 == 0) ? AW'(16) : AW'(32))) begin
        errors++; $display("FAIL rr_addr: slot %0d got %0d", i, ram_addr);
      end
      tick();
    end
    idle_inputs();
    repeat (L + 1) tick();
  endtask

  task automatic test_starvation();
    int idx, pos;
    logic [2:0] want;
    do_reset();
    m0_req = 1'b1; m0_addr = 32'h200;
    m1_req = 1'b1; m1_addr = 32'h40;
    m2_req = 1'b1; m2_addr = 32'h80;
    for (int i = 0; i < 20; i++) begin
      idx  = i % (2 * (int'(SM) + 1));
      pos  = idx % (int'(SM) + 1);
      want = (pos < int'(SM)) ? 3'b001 : ((idx < int'(SM) + 1) ? 3'b010 : 3'b100);
      @(negedge clk);
      checks++;
      if (gnts !== want) begin errors++; $display("FAIL starve_gnt: slot %0d got %b want %b", i, gnts, want); end
      tick();
    end
    idle_inputs();
    repeat (L + 1) tick();
  endtask

  task automatic test_latency_order();
    logic [2:0] want;
    do_reset();
    m0_req = 1'b1; m0_addr = 32'h100;
    for (int k = 0; k <= int'(L) + 3; k++) begin
      @(negedge clk);
      if (k < 3) begin
        checks++;
        if (gnts !== 3'(1 << k)) begin errors++; $display("FAIL order_gnt: cycle %0d got %b", k, gnts); end
      end
      want = (k >= int'(L) && k < int'(L) + 3) ? 3'(1 << (k - int'(L))) : 3'b000;
      checks++;
      if (rvs !== want) begin errors++; $display("FAIL order_rvalid: cycle %0d got %b want %b", k, rvs, want); end
      if (want != 3'b000) begin
        checks++;
        if (rdata !== shadow[64 + k - int'(L)]) begin
          errors++; $display("FAIL order_rdata: cycle %0d got %h want %h", k, rdata, shadow[64 + k - int'(L)]);
        end
      end
      tick();
      idle_inputs();
      if (k == 0) begin m1_req = 1'b1; m1_addr = 32'h104; end
      if (k == 1) begin m2_req = 1'b1; m2_addr = 32'h108; end
    end
  endtask

  task automatic test_reset_midflight();
    logic [2:0] want;
    do_reset();
    m1_req = 1'b1; m1_addr = 32'h44;
    @(negedge clk);
    checks++;
    if (gnts !== 3'b010) begin errors++; $display("FAIL mid_pre_gnt: got %b want 010", gnts); end
    tick();
    idle_inputs();
    repeat (L + 1) tick();
    m0_req = 1'b1; m0_addr = 32'h104;
    @(negedge clk);
    checks++;
    if (gnts !== 3'b001) begin errors++; $display("FAIL mid_m0_gnt: got %b want 001", gnts); end
    tick();
    reset_n = 1'b0;
    m1_req = 1'b1; m1_we = 1'b1; m2_req = 1'b1; m2_addr = 32'h48;
    @(negedge clk);
    checks++;
    if ({gnts, rvs, ram_en, ram_we} !== 8'b0) begin
      errors++; $display("FAIL mid_reset_out: gnt/rv/en/we got %b want 0", {gnts, rvs, ram_en, ram_we});
    end
    tick();
    reset_n = 1'b1; m0_req = 1'b0; m1_we = 1'b0;
    for (int k = 0; k <= int'(L) + 2; k++) begin
      @(negedge clk);
      if (k < 2) begin
        checks++;
        if (gnts !== ((k == 0) ? 3'b010 : 3'b100)) begin
          errors++; $display("FAIL mid_post_gnt: cycle %0d got %b", k, gnts);
        end
      end
      want = (k == int'(L)) ? 3'b010 : ((k == int'(L) + 1) ? 3'b100 : 3'b000);
      checks++;
      if (rvs !== want) begin errors++; $display("FAIL mid_rvalid: cycle %0d got %b want %b", k, rvs, want); end
      tick();
      if (k == 0) m1_req = 1'b0;
      if (k == 1) m2_req = 1'b0;
    end
  endtask

  task automatic test_random();
    int   vid_run;
    bit   pref_m1;
    int   win, w;
    bit   cpu;
    logic [2:0] want;
    ret_t r;
    logic [31:0] a;
    do_reset();
    exp_q.delete();
    vid_run = 0;
    pref_m1 = 1'b1;
    for (int n = 0; n < 420; n++) begin
      @(negedge clk);
      cpu = m1_req || m2_req;
      win = -1;
      if (cpu && (vid_run == int'(SM) || !m0_req)) win = (m1_req && (!m2_req || pref_m1)) ? 1 : 2;
      else if (m0_req) win = 0;
      want = (win < 0) ? 3'b000 : 3'(1 << win);
      checks++;
      if (gnts !== want) begin errors++; $display("FAIL rand_gnt: cyc %0d got %b want %b", cyc, gnts, want); end
      checks++;
      if (ram_en !== (win >= 0)) begin errors++; $display("FAIL rand_en: cyc %0d got %b", cyc, ram_en); end
      w = 0;
      if (win >= 0) begin
        a = (win == 0) ? m0_addr : ((win == 1) ? m1_addr : m2_addr);
        w = int'((a >> 2) % WORDS);
        checks++;
        if (ram_addr !== AW'(w)) begin errors++; $display("FAIL rand_addr: cyc %0d got %0d want %0d", cyc, ram_addr, w); end
        checks++;
        if (win == 1) begin
          if ({ram_we, ram_be, ram_wdata} !== {m1_we, m1_be, m1_wdata}) begin
            errors++; $display("FAIL rand_wr: cyc %0d got %b/%b/%h", cyc, ram_we, ram_be, ram_wdata);
          end
        end else if ({ram_we, ram_be} !== 5'b01111) begin
          errors++; $display("FAIL rand_rd: cyc %0d we/be got %b want 01111", cyc, {ram_we, ram_be});
        end
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        r = exp_q.pop_front();
        checks++;
        if (rvs !== 3'(1 << r.id) || rdata !== r.data) begin
          errors++; $display("FAIL rand_ret: cyc %0d got %b/%h want %b/%h", cyc, rvs, rdata, 3'(1 << r.id), r.data);
        end
      end else begin
        checks++;
        if (rvs !== 3'b000) begin errors++; $display("FAIL rand_norv: cyc %0d got %b", cyc, rvs); end
      end
      // Model update for the access accepted at the coming edge.
      if (win == 1 && m1_we) begin
        for (int b = 0; b < 4; b++) if (m1_be[b]) shadow[w][8*b +: 8] = m1_wdata[8*b +: 8];
      end else if (win >= 0) begin
        exp_q.push_back('{due: cyc + int'(L), id: win, data: shadow[w]});
      end
      vid_run = (win == 0 && cpu) ? vid_run + 1 : 0;
      if (win == 1) pref_m1 = 1'b0;
      if (win == 2) pref_m1 = 1'b1;
      tick();
      if (win == 0) m0_req = 1'b0;
      if (win == 1) m1_req = 1'b0;
      if (win == 2) m2_req = 1'b0;
      if (n < 400) begin
        if (!m0_req && $urandom_range(0, 2) != 0) begin
          a = $urandom; a[11:2] = 10'($urandom_range(0, 15)); m0_req = 1'b1; m0_addr = a;
        end
        if (!m1_req && $urandom_range(0, 2) != 0) begin
          a = $urandom; a[11:2] = 10'($urandom_range(0, 15)); m1_req = 1'b1; m1_addr = a;
          m1_we = ($urandom_range(0, 2) == 0); m1_be = 4'($urandom); m1_wdata = $urandom;
        end
        if (!m2_req && $urandom_range(0, 2) != 0) begin
          a = $urandom; a[11:2] = 10'($urandom_range(0, 15)); m2_req = 1'b1; m2_addr = a;
        end
      end
    end
    checks++;
    if (exp_q.size() != 0 || gnts !== 3'b000) begin
      errors++; $display("FAIL rand_drain: %0d reads never returned, gnt %b", exp_q.size(), gnts);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    preload = 1'b1;
    for (int i = 0; i < int'(WORDS); i++) shadow[i] = init_word(i);
    repeat (2) @(posedge clk);
    #1;
    preload = 1'b0;
    reset_n = 1'b1;
    tick();
    test_reset();
    test_single_read();
    test_write();
    test_round_robin();
    test_starvation();
    test_latency_order();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
